// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and fixed-point narrowing helpers for the backprop layer engine
//
// Contents:
//   state_t     engine FSM states
//   ONE         fixed-point 1.0 for the default FRAC_BITS (the engine derives its own from its parameter)
//   fx_narrow() narrows a sign-extended 64-bit value to w bits
//   fx_ovf()    reports whether a value lies outside the signed w-bit range
// Configuration macro: BP_SATURATE_EN
//   defined   -> fx_narrow clamps to [-2^(w-1), 2^(w-1)-1]
//   undefined -> fx_narrow keeps the low w bits (two's-complement wrap)

package bp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_NRN,
    DERIV,
    DELTA,
    UPDATE,
    FLUSH,
    DONE
  } state_t;

  localparam int DEF_FRAC_BITS = 8;
  localparam int ONE           = 1 << DEF_FRAC_BITS;

  // Result is returned sign-extended to 64 bits; callers keep the low w bits.
  function automatic logic signed [63:0] fx_narrow(input logic signed [63:0] x, input int w);
`ifdef BP_SATURATE_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
`else
    return (x <<< (64 - w)) >>> (64 - w);
`endif
  endfunction

  function automatic logic fx_ovf(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (x > hi) || (x < lo);
  endfunction

endpackage

// File: rtl/bp_fx_mul.sv
// rtl/bp_fx_mul.sv - combinational signed fixed-point multiply, floor shift and narrow
//
// Parameters: WIDTH (data width, < 32), FRAC_BITS (fractional bits)
// Ports:
//   a, b  in   WIDTH  signed operands
//   y     out  WIDTH  narrow((a*b) >>> FRAC_BITS)
//   ovf   out  1      product did not fit WIDTH bits (only with BP_SATURATE_EN)
// Configuration macro: BP_SATURATE_EN (selects saturating narrow and adds ovf)

module bp_fx_mul
  import bp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y
`ifdef BP_SATURATE_EN
  ,
  output logic                    ovf
`endif
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [63:0]        shifted;

  // Operands are sign-extended explicitly so the product keeps full 2*WIDTH precision.
  assign prod    = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  // Arithmetic shift gives floor rounding for negative products.
  assign shifted = $signed({{(64-2*WIDTH){prod[2*WIDTH-1]}}, prod}) >>> FRAC_BITS;
  assign y       = WIDTH'(fx_narrow(shifted, WIDTH));

`ifdef BP_SATURATE_EN
  assign ovf = fx_ovf(shifted, WIDTH);
`endif

endmodule

// File: rtl/backprop_layer_engine.sv
// rtl/backprop_layer_engine.sv - sequential backprop weight-update engine for one sigmoid layer
//
// Per neuron: delta = err * a*(1-a); then for each of N_IN weights:
//   gradient = delta*act_prev, new_weight = weight - lr*gradient (all fixed point).
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start, learning_rate        begin a pass (IDLE only); lr latched on accepted start
//   busy, done                  pass in progress; one-cycle completion pulse
//   nrn_valid/nrn_ready         neuron beat: act_cur, err_in
//   w_valid/w_ready             weight beat: act_prev, weight_in
//   out_valid/out_ready         result beat: new_weight, gradient, delta,
//                               out_nrn_idx, out_w_idx, out_last
//   sat_flag                    sticky narrowing-overflow flag, cleared by start
//                               (only with BP_SATURATE_EN)
// Configuration macro: BP_SATURATE_EN (saturating narrowing + sat_flag; default wraps)

module backprop_layer_engine
  import bp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8,
  parameter int N_IN      = 8,
  parameter int N_OUT     = 4,
  localparam int NW       = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int IW       = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] learning_rate,
  output logic             busy,
  output logic             done,
  input  logic             nrn_valid,
  output logic             nrn_ready,
  input  logic [WIDTH-1:0] act_cur,
  input  logic [WIDTH-1:0] err_in,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [WIDTH-1:0] act_prev,
  input  logic [WIDTH-1:0] weight_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] new_weight,
  output logic [WIDTH-1:0] gradient,
  output logic [WIDTH-1:0] delta,
  output logic [NW-1:0]    out_nrn_idx,
  output logic [IW-1:0]    out_w_idx,
`ifdef BP_SATURATE_EN
  output logic             sat_flag,
`endif
  output logic             out_last
);

  localparam logic [WIDTH:0]  ONE_X    = (WIDTH+1)'(1) << FRAC_BITS;
  localparam logic [NW-1:0]   LAST_NRN = NW'(N_OUT - 1);
  localparam logic [IW-1:0]   LAST_W   = IW'(N_IN - 1);

  state_t                  state;
  logic signed [WIDTH-1:0] lr_q;
  logic signed [WIDTH-1:0] a_q;
  logic signed [WIDTH-1:0] err_q;
  logic signed [WIDTH-1:0] d_q;
  logic [NW-1:0]           nrn_idx;
  logic [IW-1:0]           w_idx;

  logic signed [WIDTH:0]   one_minus_a_x;
  logic signed [WIDTH-1:0] one_minus_a;
  logic signed [WIDTH-1:0] m0_a;
  logic signed [WIDTH-1:0] m0_b;
  logic signed [WIDTH-1:0] m0_y;
  logic signed [WIDTH-1:0] grad_n;
  logic signed [WIDTH-1:0] lrg_n;
  logic signed [WIDTH:0]   diff_x;
  logic signed [WIDTH-1:0] nw_n;
  logic                    w_hs;

  // 1 - a needs one extra bit: a may be any signed value, not just a sigmoid output.
  assign one_minus_a_x = ONE_X - {a_q[WIDTH-1], a_q};
  assign one_minus_a   = WIDTH'(fx_narrow({{(63-WIDTH){one_minus_a_x[WIDTH]}}, one_minus_a_x}, WIDTH));

  // DERIV and DELTA never overlap, so one multiplier serves both.
  always_comb begin
    m0_a = err_q;
    m0_b = d_q;
    if (state == DERIV) begin
      m0_a = a_q;
      m0_b = one_minus_a;
    end
  end

`ifdef BP_SATURATE_EN
  logic m0_ovf, g_ovf, u_ovf, oma_ovf, sub_ovf;
  assign oma_ovf = fx_ovf({{(63-WIDTH){one_minus_a_x[WIDTH]}}, one_minus_a_x}, WIDTH);
  assign sub_ovf = fx_ovf({{(63-WIDTH){diff_x[WIDTH]}}, diff_x}, WIDTH);
`endif

  bp_fx_mul #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_shared (
    .a (m0_a),
    .b (m0_b),
    .y (m0_y)
`ifdef BP_SATURATE_EN
    ,
    .ovf (m0_ovf)
`endif
  );

  bp_fx_mul #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_grad (
    .a (delta),
    .b (act_prev),
    .y (grad_n)
`ifdef BP_SATURATE_EN
    ,
    .ovf (g_ovf)
`endif
  );

  bp_fx_mul #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_update (
    .a (lr_q),
    .b (grad_n),
    .y (lrg_n)
`ifdef BP_SATURATE_EN
    ,
    .ovf (u_ovf)
`endif
  );

  assign diff_x = {weight_in[WIDTH-1], weight_in} - {lrg_n[WIDTH-1], lrg_n};
  assign nw_n   = WIDTH'(fx_narrow({{(63-WIDTH){diff_x[WIDTH]}}, diff_x}, WIDTH));

  // Accept a weight only when the output register is empty or being drained this cycle.
  assign w_ready = (state == UPDATE) && (!out_valid || out_ready);
  assign w_hs    = w_valid && w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lr_q        <= '0;
      a_q         <= '0;
      err_q       <= '0;
      d_q         <= '0;
      nrn_idx     <= '0;
      w_idx       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      nrn_ready   <= 1'b0;
      out_valid   <= 1'b0;
      new_weight  <= '0;
      gradient    <= '0;
      delta       <= '0;
      out_nrn_idx <= '0;
      out_w_idx   <= '0;
      out_last    <= 1'b0;
`ifdef BP_SATURATE_EN
      sat_flag    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      // Drained results clear here; a newly accepted beat below overrides this.
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          nrn_idx <= '0;
          w_idx   <= '0;
          if (start) begin
            lr_q      <= learning_rate;
            busy      <= 1'b1;
            nrn_ready <= 1'b1;
            state     <= GET_NRN;
`ifdef BP_SATURATE_EN
            sat_flag  <= 1'b0;
`endif
          end
        end

        GET_NRN: begin
          if (nrn_valid) begin
            a_q       <= act_cur;
            err_q     <= err_in;
            nrn_ready <= 1'b0;
            state     <= DERIV;
          end
        end

        DERIV: begin
          d_q   <= m0_y;
          state <= DELTA;
`ifdef BP_SATURATE_EN
          if (m0_ovf || oma_ovf) sat_flag <= 1'b1;
`endif
        end

        DELTA: begin
          delta <= m0_y;
          state <= UPDATE;
`ifdef BP_SATURATE_EN
          if (m0_ovf) sat_flag <= 1'b1;
`endif
        end

        UPDATE: begin
          if (w_hs) begin
            out_valid   <= 1'b1;
            gradient    <= grad_n;
            new_weight  <= nw_n;
            out_nrn_idx <= nrn_idx;
            out_w_idx   <= w_idx;
            out_last    <= (nrn_idx == LAST_NRN) && (w_idx == LAST_W);
`ifdef BP_SATURATE_EN
            if (g_ovf || u_ovf || sub_ovf) sat_flag <= 1'b1;
`endif
            if (w_idx == LAST_W) begin
              w_idx <= '0;
              if (nrn_idx == LAST_NRN) begin
                state <= FLUSH;
              end else begin
                nrn_idx   <= nrn_idx + NW'(1);
                nrn_ready <= 1'b1;
                state     <= GET_NRN;
              end
            end else begin
              w_idx <= w_idx + IW'(1);
            end
          end
        end

        FLUSH: begin
          if (!out_valid || out_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
